// File: rtl/gomoku_pkg.sv
// Shared types and direction helpers for the gomoku board controller.
package gomoku_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BLACK = 2'd1,
      WHITE = 2'd2
   } cell_t;

   typedef enum logic [1:0] {
      H = 2'd0,
      V = 2'd1,
      D = 2'd2,
      A = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      IDLE    = 2'd1,
      SCAN    = 2'd2,
      RESOLVE = 2'd3
   } state_t;

   // Column step of a scan direction (+ side).
   function automatic logic signed [1:0] dir_dx(input dir_t d);
      case (d)
         H:       dir_dx = 2'sb01;
         V:       dir_dx = 2'sb00;
         D:       dir_dx = 2'sb01;
         A:       dir_dx = 2'sb01;
         default: dir_dx = 2'sb00;
      endcase
   endfunction

   // Row step of a scan direction (+ side); A runs up-right.
   function automatic logic signed [1:0] dir_dy(input dir_t d);
      case (d)
         H:       dir_dy = 2'sb00;
         V:       dir_dy = 2'sb01;
         D:       dir_dy = 2'sb01;
         A:       dir_dy = 2'sb11;
         default: dir_dy = 2'sb00;
      endcase
   endfunction

   // Stone colour (0 black, 1 white) to the cell code it occupies.
   function automatic cell_t color_cell(input logic c);
      if (c) begin
         color_cell = WHITE;
      end else begin
         color_cell = BLACK;
      end
   endfunction

endpackage

// File: rtl/gomoku_board_mem.sv
// N*N two-bit board storage: one synchronous write port, two combinational
// read ports (scan probe and display). Cell index is N*x + y.
module gomoku_board_mem
   import gomoku_pkg::*;
#(
   parameter int N  = 7,
   parameter int AW = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  cell_t         wr_cell,
   input  logic [AW-1:0] probe_idx,
   output cell_t         probe_cell,
   input  logic [AW-1:0] disp_idx,
   output cell_t         disp_cell
);

   localparam int NN = N * N;

   cell_t cells [NN];

   // Single write port shared by the clear sweep and move placement.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         cells[wr_idx] <= wr_cell;
      end
   end

   // Combinational reads; indices past the board read as empty.
   always_comb begin
      probe_cell = EMPTY;
      disp_cell  = EMPTY;
      if (int'(probe_idx) < NN) begin
         probe_cell = cells[probe_idx];
      end else begin
         probe_cell = EMPTY;
      end
      if (int'(disp_idx) < NN) begin
         disp_cell = cells[disp_idx];
      end else begin
         disp_cell = EMPTY;
      end
   end

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Gomoku board controller: move handshake, sequential line scanner for
// WIN_LEN-in-a-row detection, turn tracking and draw detection.
module gomoku_board_ctrl
   import gomoku_pkg::*;
#(
   parameter  int N       = 7,
   parameter  int WIN_LEN = 5,
   localparam int CW      = $clog2(N),
   localparam int SW      = $clog2(N*N+1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          new_game,
   input  logic          move_valid,
   output logic          move_ready,
   input  logic [CW-1:0] move_x,
   input  logic [CW-1:0] move_y,
   output logic          move_done,
   output logic          move_rej,
   output logic          turn,
   input  logic [CW-1:0] rd_x,
   input  logic [CW-1:0] rd_y,
   output logic [1:0]    rd_cell,
   output logic [SW-1:0] stones,
   output logic          game_over,
   output logic          win_valid,
   output logic          win_color,
   output logic          draw
);

   localparam int NN   = N * N;
   localparam int AW   = $clog2(NN);
   localparam int KW   = $clog2(WIN_LEN);
   localparam int CNTW = $clog2(WIN_LEN + 1);

   localparam logic [CW:0]     N_W      = (CW+1)'(N);
   localparam logic [AW-1:0]   LAST_IDX = AW'(NN - 1);
   localparam logic [SW-1:0]   FULL     = SW'(NN);
   localparam logic [KW-1:0]   K_MAX    = KW'(WIN_LEN - 1);
   localparam logic [CNTW-1:0] CNT_WIN  = CNTW'(WIN_LEN);

   // Flat cell index N*x + y.
   function automatic logic [AW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
      cell_idx = AW'(x) * AW'(N) + AW'(y);
   endfunction

   // One step of k cells from coordinate c in direction s (-1, 0, +1).
   function automatic logic signed [CW:0] step_coord(input logic [CW-1:0] c,
                                                     input logic signed [1:0] s,
                                                     input logic signed [CW:0] k);
      logic signed [CW:0] base;
      base = signed'({1'b0, c});
      case (s)
         2'sb01:  step_coord = base + k;
         2'sb11:  step_coord = base - k;
         default: step_coord = base;
      endcase
   endfunction

   // Registers
   state_t          state_r;
   logic [AW-1:0]   clr_idx_r;
   logic            turn_r;
   logic [SW-1:0]   stones_r;
   logic            win_valid_r;
   logic            win_color_r;
   logic            draw_r;
   logic            move_done_r;
   logic            move_rej_r;
   logic [CW-1:0]   lx_r;
   logic [CW-1:0]   ly_r;
   logic            lcol_r;
   logic [CNTW-1:0] cnt_r;
   dir_t            dir_r;
   logic            side_r;
   logic [KW-1:0]   k_r;
   logic            win_hit_r;

   // Combinational signals
   logic               game_over_s;
   logic               ready_s;
   logic               handshake_s;
   logic               in_range_s;
   logic               legal_s;
   logic [AW-1:0]      move_idx_s;
   logic signed [1:0]  sx_s;
   logic signed [1:0]  sy_s;
   logic signed [CW:0] k_s;
   logic signed [CW:0] px_s;
   logic signed [CW:0] py_s;
   logic               on_board_s;
   logic [AW-1:0]      scan_idx_s;
   logic               match_s;
   logic               win_now_s;
   logic               side_end_s;
   logic               wr_en_s;
   logic [AW-1:0]      wr_idx_s;
   cell_t              wr_cell_s;
   logic [AW-1:0]      probe_idx_s;
   cell_t              probe_cell_s;
   logic [AW-1:0]      disp_idx_s;
   cell_t              disp_cell_s;

   gomoku_board_mem #(
      .N  (N),
      .AW (AW)
   ) u_mem (
      .clk        (clk),
      .wr_en      (wr_en_s),
      .wr_idx     (wr_idx_s),
      .wr_cell    (wr_cell_s),
      .probe_idx  (probe_idx_s),
      .probe_cell (probe_cell_s),
      .disp_idx   (disp_idx_s),
      .disp_cell  (disp_cell_s)
   );

   // Handshake qualification and legality of the requested cell.
   always_comb begin
      game_over_s = win_valid_r | draw_r;
      ready_s     = (state_r == IDLE) && !game_over_s && !new_game;
      handshake_s = move_valid && ready_s;
      in_range_s  = ({1'b0, move_x} < N_W) && ({1'b0, move_y} < N_W);
      move_idx_s  = cell_idx(move_x, move_y);
      legal_s     = in_range_s && (probe_cell_s == EMPTY);
   end

   // Scan probe position: latched move plus k steps along the current direction/side.
   always_comb begin
      sx_s       = side_r ? -dir_dx(dir_r) : dir_dx(dir_r);
      sy_s       = side_r ? -dir_dy(dir_r) : dir_dy(dir_r);
      k_s        = signed'((CW+1)'(k_r));
      px_s       = step_coord(lx_r, sx_s, k_s);
      py_s       = step_coord(ly_r, sy_s, k_s);
      on_board_s = !px_s[CW] && !py_s[CW] &&
                   ($unsigned(px_s) < N_W) && ($unsigned(py_s) < N_W);
      scan_idx_s = cell_idx(px_s[CW-1:0], py_s[CW-1:0]);
      match_s    = on_board_s && (probe_cell_s == color_cell(lcol_r));
      win_now_s  = match_s && ((cnt_r + CNTW'(1)) == CNT_WIN);
      side_end_s = !match_s || (k_r == K_MAX);
   end

   // Board port muxing: probe port checks occupancy in IDLE and walks lines in SCAN.
   always_comb begin
      probe_idx_s = move_idx_s;
      wr_en_s     = 1'b0;
      wr_idx_s    = move_idx_s;
      wr_cell_s   = EMPTY;
      if (state_r == SCAN) begin
         probe_idx_s = scan_idx_s;
      end else begin
         probe_idx_s = move_idx_s;
      end
      if (state_r == CLEAR) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = clr_idx_r;
         wr_cell_s = EMPTY;
      end else begin
         wr_en_s   = handshake_s && legal_s;
         wr_idx_s  = move_idx_s;
         wr_cell_s = color_cell(turn_r);
      end
   end

   // Display read: forced empty during the clear sweep or for off-board addresses.
   always_comb begin
      disp_idx_s = cell_idx(rd_x, rd_y);
      rd_cell    = EMPTY;
      if ((state_r != CLEAR) && ({1'b0, rd_x} < N_W) && ({1'b0, rd_y} < N_W)) begin
         rd_cell = disp_cell_s;
      end else begin
         rd_cell = EMPTY;
      end
   end

   // Main FSM: clear sweep, move handshake, line scan and result resolution.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= CLEAR;
         clr_idx_r   <= '0;
         turn_r      <= 1'b0;
         stones_r    <= '0;
         win_valid_r <= 1'b0;
         win_color_r <= 1'b0;
         draw_r      <= 1'b0;
         move_done_r <= 1'b0;
         move_rej_r  <= 1'b0;
         lx_r        <= '0;
         ly_r        <= '0;
         lcol_r      <= 1'b0;
         cnt_r       <= '0;
         dir_r       <= H;
         side_r      <= 1'b0;
         k_r         <= '0;
         win_hit_r   <= 1'b0;
      end else begin
         move_done_r <= 1'b0;
         move_rej_r  <= 1'b0;
         if (new_game) begin
            state_r     <= CLEAR;
            clr_idx_r   <= '0;
            turn_r      <= 1'b0;
            stones_r    <= '0;
            win_valid_r <= 1'b0;
            win_color_r <= 1'b0;
            draw_r      <= 1'b0;
            win_hit_r   <= 1'b0;
         end else begin
            case (state_r)
               CLEAR: begin
                  if (clr_idx_r == LAST_IDX) begin
                     clr_idx_r <= '0;
                     state_r   <= IDLE;
                  end else begin
                     clr_idx_r <= clr_idx_r + AW'(1);
                  end
               end
               IDLE: begin
                  if (handshake_s) begin
                     if (!legal_s) begin
                        move_rej_r <= 1'b1;
                     end else begin
                        stones_r  <= stones_r + SW'(1);
                        lx_r      <= move_x;
                        ly_r      <= move_y;
                        lcol_r    <= turn_r;
                        cnt_r     <= CNTW'(1);
                        dir_r     <= H;
                        side_r    <= 1'b0;
                        k_r       <= KW'(1);
                        win_hit_r <= 1'b0;
                        state_r   <= SCAN;
                     end
                  end
               end
               SCAN: begin
                  if (win_now_s) begin
                     win_hit_r <= 1'b1;
                     state_r   <= RESOLVE;
                  end else begin
                     if (match_s) begin
                        cnt_r <= cnt_r + CNTW'(1);
                     end
                     if (side_end_s) begin
                        k_r <= KW'(1);
                        if (!side_r) begin
                           side_r <= 1'b1;
                        end else if (dir_r == A) begin
                           state_r <= RESOLVE;
                        end else begin
                           dir_r  <= dir_t'(dir_r + 2'd1);
                           side_r <= 1'b0;
                           cnt_r  <= CNTW'(1);
                        end
                     end else begin
                        k_r <= k_r + KW'(1);
                     end
                  end
               end
               RESOLVE: begin
                  move_done_r <= 1'b1;
                  if (win_hit_r) begin
                     win_valid_r <= 1'b1;
                     win_color_r <= lcol_r;
                  end else if (stones_r == FULL) begin
                     draw_r <= 1'b1;
                  end else begin
                     turn_r <= ~turn_r;
                  end
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= CLEAR;
               end
            endcase
         end
      end
   end

   assign move_ready = ready_s;
   assign move_done  = move_done_r;
   assign move_rej   = move_rej_r;
   assign turn       = turn_r;
   assign stones     = stones_r;
   assign game_over  = game_over_s;
   assign win_valid  = win_valid_r;
   assign win_color  = win_color_r;
   assign draw       = draw_r;

endmodule
